// File: rtl/mem_req_arbiter.sv
// Single-outstanding arbiter: MMU data requests win over instruction fetch, with a
// starvation guard for fetch. Optional busy-timeout abort when ARB_TIMEOUT_EN is defined.
module mem_req_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_req_valid,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    output logic                  i_req_ready,
    output logic                  i_resp_valid,
    output logic [DATA_WIDTH-1:0] i_resp_data,
    output logic                  i_resp_err,
    input  logic                  d_req_valid,
    input  logic [ADDR_WIDTH-1:0] d_req_addr,
    input  logic [DATA_WIDTH-1:0] d_req_wdata,
    input  logic                  d_req_we,
    output logic                  d_req_ready,
    output logic                  d_resp_valid,
    output logic [DATA_WIDTH-1:0] d_resp_data,
    output logic                  d_resp_err,
    output logic                  mem_req_valid,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } state_t;

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    state_t                state_r;
    state_t                state_nxt_s;
    logic [SW-1:0]         starve_cnt_r;
    logic                  grant_i_s;
    logic                  grant_d_s;
    logic                  done_s;
    logic                  abort_s;
    logic [DATA_WIDTH-1:0] resp_data_s;

    assign done_s = (state_r != ST_IDLE) && mem_ack;

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] busy_cnt_r;

    // Counts busy cycles; parked at zero in IDLE so every transaction starts fresh
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_cnt_r <= {TW{1'b0}};
        end else if (state_r == ST_IDLE) begin
            busy_cnt_r <= {TW{1'b0}};
        end else begin
            busy_cnt_r <= busy_cnt_r + TW'(1);
        end
    end

    // An ack in the final busy cycle wins over the timeout
    assign abort_s = (state_r != ST_IDLE) && !mem_ack &&
                     (busy_cnt_r == TW'(TIMEOUT_CYCLES - 1));
`else
    localparam int timeout_cycles_unused = TIMEOUT_CYCLES;
    assign abort_s = 1'b0;
`endif

    // Arbitration: ready is combinational from request valids and state
    always_comb begin
        grant_i_s = 1'b0;
        grant_d_s = 1'b0;
        if (state_r == ST_IDLE) begin
            if (d_req_valid && i_req_valid) begin
                if (starve_cnt_r == STARVE_MAX) begin
                    grant_i_s = 1'b1;
                end else begin
                    grant_d_s = 1'b1;
                end
            end else if (d_req_valid) begin
                grant_d_s = 1'b1;
            end else if (i_req_valid) begin
                grant_i_s = 1'b1;
            end else begin
                grant_i_s = 1'b0;
            end
        end else begin
            grant_d_s = 1'b0;
        end
    end

    assign i_req_ready = grant_i_s;
    assign d_req_ready = grant_d_s;

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_d_s) begin
                    state_nxt_s = ST_BUSY_D;
                end else if (grant_i_s) begin
                    state_nxt_s = ST_BUSY_I;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                if (done_s || abort_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Response data: writes and aborts return zero
    always_comb begin
        resp_data_s = {DATA_WIDTH{1'b0}};
        if (done_s && !mem_we) begin
            resp_data_s = mem_rdata;
        end else begin
            resp_data_s = {DATA_WIDTH{1'b0}};
        end
    end

    // Starvation counter: consecutive data wins while fetch was waiting
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_r <= {SW{1'b0}};
        end else if (grant_i_s) begin
            starve_cnt_r <= {SW{1'b0}};
        end else if (grant_d_s) begin
            if (!i_req_valid) begin
                starve_cnt_r <= {SW{1'b0}};
            end else if (starve_cnt_r != STARVE_MAX) begin
                starve_cnt_r <= starve_cnt_r + SW'(1);
            end
        end
    end

    // Memory port and response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req_valid <= 1'b0;
            mem_addr      <= {ADDR_WIDTH{1'b0}};
            mem_wdata     <= {DATA_WIDTH{1'b0}};
            mem_we        <= 1'b0;
            i_resp_valid  <= 1'b0;
            i_resp_data   <= {DATA_WIDTH{1'b0}};
            i_resp_err    <= 1'b0;
            d_resp_valid  <= 1'b0;
            d_resp_data   <= {DATA_WIDTH{1'b0}};
            d_resp_err    <= 1'b0;
        end else begin
            i_resp_valid <= 1'b0;
            i_resp_err   <= 1'b0;
            d_resp_valid <= 1'b0;
            d_resp_err   <= 1'b0;
            if (grant_d_s) begin
                mem_req_valid <= 1'b1;
                mem_addr      <= d_req_addr;
                mem_wdata     <= d_req_wdata;
                mem_we        <= d_req_we;
            end else if (grant_i_s) begin
                mem_req_valid <= 1'b1;
                mem_addr      <= i_req_addr;
                mem_wdata     <= {DATA_WIDTH{1'b0}};
                mem_we        <= 1'b0;
            end else if (done_s || abort_s) begin
                mem_req_valid <= 1'b0;
                mem_addr      <= {ADDR_WIDTH{1'b0}};
                mem_wdata     <= {DATA_WIDTH{1'b0}};
                mem_we        <= 1'b0;
                if (state_r == ST_BUSY_I) begin
                    i_resp_valid <= 1'b1;
                    i_resp_err   <= abort_s;
                    i_resp_data  <= resp_data_s;
                end else begin
                    d_resp_valid <= 1'b1;
                    d_resp_err   <= abort_s;
                    d_resp_data  <= resp_data_s;
                end
            end
        end
    end
endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Arbitrates between the instruction-fetch port and the MMU data port (addr_req/data_req/We_req bus) onto a single instruction/data memory port.
- One transaction is outstanding at a time. Data requests have priority, with a starvation guard for fetch.
- Request fields are latched and held stable until the memory acknowledges. A one-cycle response pulse is returned to the winning requester.

Parameters:
- ADDR_WIDTH, 32, address width (matches `ADDR_WIDTH).
- DATA_WIDTH, 32, data width (matches `DATA_WIDTH).
- STARVE_LIMIT, 4, consecutive data grants while fetch waits before fetch is forced.
- TIMEOUT_CYCLES, 64, busy cycles before abort (used only with the optional feature).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- i_req_valid  in  1  fetch request.
- i_req_addr  in  ADDR_WIDTH  fetch address.
- i_req_ready  out  1  fetch request accepted this cycle.
- i_resp_valid  out  1  fetch response pulse.
- i_resp_data  out  DATA_WIDTH  fetch read data.
- i_resp_err  out  1  fetch aborted by timeout.
- d_req_valid  in  1  MMU request (We_req path).
- d_req_addr  in  ADDR_WIDTH  MMU address (addr_req).
- d_req_wdata  in  DATA_WIDTH  MMU write data (data_req).
- d_req_we  in  1  1 = write, 0 = read.
- d_req_ready  out  1  MMU request accepted this cycle.
- d_resp_valid  out  1  MMU response pulse.
- d_resp_data  out  DATA_WIDTH  MMU read data.
- d_resp_err  out  1  MMU transaction aborted by timeout.
- mem_req_valid  out  1  memory request active.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_we  out  1  memory write enable.
- mem_ack  in  1  memory completion pulse; read data valid this cycle.
- mem_rdata  in  DATA_WIDTH  memory read data.

Behaviour:
- Reset values: all outputs 0, state IDLE, starve counter 0. Reset mid-transaction drops the transaction silently: mem_req_valid is 0 in the next cycle and no response pulse is issued.

States:
- IDLE: no transaction in flight.
- BUSY_I: fetch transaction in flight.
- BUSY_D: data transaction in flight.

Arbitration (IDLE only; ready is combinational from valid and state):
- Only d valid -> grant d.
- Only i valid -> grant i.
- Both valid -> grant d, unless starve counter == STARVE_LIMIT, then grant i.
- Exactly one ready is asserted, and only in IDLE.
- On valid && ready: latch addr/wdata/we (fetch latches we = 0, wdata = 0). Next state is BUSY_I or BUSY_D.

Starve counter:
- +1 (saturating at STARVE_LIMIT) on a d grant while i_req_valid is high.
- Cleared on an i grant, and on a d grant while i_req_valid is low.

BUSY_x:
- mem_req_valid = 1; mem_addr/mem_wdata/mem_we hold the latched values, stable until ack.
- On mem_ack: next cycle is IDLE. The owner's resp_valid = 1 for exactly one cycle and resp_data = mem_rdata captured at ack (0 for writes).
- A new request may be accepted in that same IDLE cycle, so back-to-back issue is possible.

Latency:
- Accept at cycle T, mem_req_valid from T+1. Ack at T+1 gives resp_valid at T+2 (minimum 2 cycles).

Other rules:
- In IDLE, mem_addr/mem_wdata/mem_we drive 0.
- mem_ack outside BUSY is ignored.
- resp_data holds its last value when resp_valid = 0.

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - A busy counter clears on entry to BUSY_x and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES without mem_ack: next cycle is IDLE, mem_req_valid = 0, the owner's resp_valid = 1 with resp_err = 1 and resp_data = 0.
  - mem_ack arriving in the same cycle as the timeout takes precedence (normal completion, err = 0).
- Undefined:
  - No counter exists; BUSY waits indefinitely.
  - i_resp_err and d_resp_err are tied to 0.

Test Plan:
- Single fetch: i_req addr 0x100, mem_ack 3 cycles after mem_req_valid rises with rdata 0x00500093 -> i_resp_valid one cycle after ack, i_resp_data 0x00500093, d_resp_valid stays 0.
- Data write: d_req addr 0x2000, wdata 0xCAFEF00D, we = 1 -> mem_we = 1, mem_addr/wdata stable throughout BUSY, d_resp_valid pulse with data 0.
- Contention and starvation:
  - Stimulus: i_req_valid held high, d_req_valid held high, ack in 1 cycle each.
  - Response: grant order d,d,d,d,i,d,d,d,d,i (STARVE_LIMIT = 4).
- Back-to-back:
  - Stimulus: d read acked at T; new d request valid at T+1.
  - Response: d_resp_valid and d_req_ready both high at T+1; mem_req_valid high again at T+2.
- Reset mid-op:
  - Stimulus: reset asserted for 1 cycle during BUSY_D, no ack.
  - Response: mem_req_valid = 0 next cycle; no d_resp_valid; a later i request is granted normally.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 8:
  - Stimulus: d read, never acked.
  - Response: after 8 busy cycles, d_resp_valid = 1, d_resp_err = 1, d_resp_data = 0; mem_req_valid drops.
